// File: rtl/flash_spi_shifter.sv
// Byte-wide mode-0 SPI master between the VME byte bus and the configuration flash pins.
// Define FLASH_OVERRUN_EN to build the sticky write-while-busy overrun flag on OVR.
module flash_spi_shifter #(
    parameter int CLKDIV = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       WS,
    input  logic       RS,
    inout  wire  [7:0] DATA,
    input  logic       SI,
    output logic       SO,
    output logic       FCK,
    output logic       NCS,
    output logic       BUSY,
    output logic       OVR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    state_t     state_q, state_d;
    logic [7:0] shiftReg_q, shiftReg_d;
    logic [7:0] rxReg_q, rxReg_d;
    logic [7:0] divCnt_q, divCnt_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic       fck_q, fck_d;
    logic       so_q, so_d;
    logic       ncs_q, ncs_d;
    logic       busy_q, busy_d;
    logic [7:0] shifted;
    logic       divLast;
    logic       startXfer;

    assign divLast   = (divCnt_q == DIV_LAST);
    assign startXfer = WS && ENABLE;
    assign shifted   = {shiftReg_q[6:0], SI};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping ENABLE takes priority over every divider-driven transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (startXfer) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (!ENABLE) begin
                    state_d = IDLE;
                end else if (divLast) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (!ENABLE) begin
                    state_d = IDLE;
                end else if (divLast) begin
                    state_d = (bitCnt_q == 3'd7) ? IDLE : LOW;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shiftReg_d = shiftReg_q;
        rxReg_d    = rxReg_q;
        divCnt_d   = divCnt_q;
        bitCnt_d   = bitCnt_q;
        fck_d      = fck_q;
        so_d       = so_q;
        busy_d     = busy_q;
        ncs_d      = ~ENABLE;
        case (state_q)
            IDLE: begin
                fck_d = 1'b0;
                if (startXfer) begin
                    shiftReg_d = DATA;
                    so_d       = DATA[7];
                    busy_d     = 1'b1;
                    bitCnt_d   = 3'd0;
                    divCnt_d   = 8'd0;
                end
            end
            LOW: begin
                if (!ENABLE) begin
                    fck_d    = 1'b0;
                    busy_d   = 1'b0;
                    divCnt_d = 8'd0;
                end else if (divLast) begin
                    fck_d    = 1'b1;
                    divCnt_d = 8'd0;
                end else begin
                    divCnt_d = divCnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (!ENABLE) begin
                    fck_d    = 1'b0;
                    busy_d   = 1'b0;
                    divCnt_d = 8'd0;
                end else if (divLast) begin
                    // Falling FCK edge: capture SI and present the next MSB.
                    fck_d      = 1'b0;
                    divCnt_d   = 8'd0;
                    shiftReg_d = shifted;
                    if (bitCnt_q == 3'd7) begin
                        rxReg_d = shifted;
                        busy_d  = 1'b0;
                    end else begin
                        so_d     = shifted[7];
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end else begin
                    divCnt_d = divCnt_q + 8'd1;
                end
            end
            default: begin
                fck_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shiftReg_q <= 8'h00;
            rxReg_q    <= 8'h00;
            divCnt_q   <= 8'd0;
            bitCnt_q   <= 3'd0;
            fck_q      <= 1'b0;
            so_q       <= 1'b0;
            ncs_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            shiftReg_q <= shiftReg_d;
            rxReg_q    <= rxReg_d;
            divCnt_q   <= divCnt_d;
            bitCnt_q   <= bitCnt_d;
            fck_q      <= fck_d;
            so_q       <= so_d;
            ncs_q      <= ncs_d;
            busy_q     <= busy_d;
        end
    end

`ifdef FLASH_OVERRUN_EN
    logic ovr_q, ovr_d;

    // A new overrun beats a simultaneous read-clear.
    always_comb begin
        ovr_d = ovr_q;
        if (WS && busy_q) begin
            ovr_d = 1'b1;
        end else if (RS) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign OVR = ovr_q;
`else
    assign OVR = 1'b0;
`endif

    assign FCK  = fck_q;
    assign SO   = so_q;
    assign NCS  = ncs_q;
    assign BUSY = busy_q;
    assign DATA = RS ? rxReg_q : 8'hzz;

endmodule
